alu_seq_ctrl: RTL

- Request/response sequencer that drives the 16-bit ALU's operand/op inputs and consumes its result and flag outputs.
- Sits between the datapath issue logic and the ALU.
- Turns single-function requests into one or more ALU cycles:
  - single-pass AND/OR/ADD/SUB;
  - two-pass SLT, which feeds the captured set flag back as less without a combinational loop;
  - optional 16-iteration shift-add multiply.
- Registers the result and flags, then presents them on a valid/ready response port.

---
 rtl/alu_seq_pkg.sv | 52 +++++
 rtl/alu_seq_ctrl.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq_pkg.sv
// Shared definitions for the ALU request sequencer: function codes, ALU op codes,
// FSM states and decode helpers. Defining ALU_SEQ_MUL_EN makes function code 5 (MUL) legal.
package alu_seq_pkg;

  localparam logic [3:0] FN_AND = 4'd0;
  localparam logic [3:0] FN_OR  = 4'd1;
  localparam logic [3:0] FN_ADD = 4'd2;
  localparam logic [3:0] FN_SUB = 4'd3;
  localparam logic [3:0] FN_SLT = 4'd4;
  localparam logic [3:0] FN_MUL = 4'd5;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_EXEC = 3'd1,
    ST_SLT2 = 3'd2,
    ST_MUL  = 3'd3,
    ST_RESP = 3'd4
  } state_t;

  // ALU op for the first pass; SLT starts with a subtract to obtain the set flag.
  function automatic logic [2:0] funct_to_op(input logic [3:0] funct);
    logic [2:0] op;
    case (funct)
      FN_AND:         op = OP_AND;
      FN_OR:          op = OP_OR;
      FN_ADD:         op = OP_ADD;
      FN_SUB, FN_SLT: op = OP_SUB;
      FN_MUL:         op = OP_ADD;
      default:        op = OP_AND;
    endcase
    return op;
  endfunction

  function automatic logic funct_legal(input logic [3:0] funct);
    logic ok;
    case (funct)
      FN_AND, FN_OR, FN_ADD, FN_SUB, FN_SLT: ok = 1'b1;
`ifdef ALU_SEQ_MUL_EN
      FN_MUL: ok = 1'b1;
`endif
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/alu_seq_ctrl.sv
// Request/response sequencer driving a 16-bit ripple ALU: single-pass logic/arith ops,
// two-pass SLT, and (with ALU_SEQ_MUL_EN defined) a shift-add multiply.
module alu_seq_ctrl
  import alu_seq_pkg::*;
#(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned MUL_ITERS = WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [3:0]       req_funct,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_op,
  output logic             alu_cin,
  output logic             alu_less,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_cout,
  input  logic             alu_set,
  input  logic             alu_zero,
  input  logic             alu_overflow,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_zero,
  output logic             rsp_overflow,
  output logic             rsp_cout,
  output logic             rsp_err
);

  if (MUL_ITERS < 1) begin : g_bad_iters
    $error("alu_seq_ctrl: MUL_ITERS must be at least 1");
  end

  state_t           r_state;
  state_t           w_state_nx;
  logic [3:0]       r_funct;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_set;
  logic [WIDTH-1:0] r_rsp_result;
  logic             r_rsp_zero;
  logic             r_rsp_overflow;
  logic             r_rsp_cout;
  logic             r_rsp_err;
  logic             w_req_ready;
  logic             w_accept;
  logic [WIDTH-1:0] w_alu_a;
  logic [WIDTH-1:0] w_alu_b;
  logic [2:0]       w_alu_op;
  logic             w_alu_less;

`ifdef ALU_SEQ_MUL_EN
  localparam int unsigned ITER_W = (MUL_ITERS > 1) ? $clog2(MUL_ITERS) : 1;
  localparam logic [ITER_W-1:0] LAST_ITER = ITER_W'(MUL_ITERS - 1);

  logic [WIDTH-1:0]  r_acc;
  logic [WIDTH-1:0]  r_mcand;
  logic [WIDTH-1:0]  r_mplier;
  logic [ITER_W-1:0] r_iter;
  logic              r_sticky_c;
  logic              r_shift_ovf;
  logic [WIDTH-1:0]  w_mplier_nx;
  logic [WIDTH-1:0]  w_mul_addend;
  logic              w_mul_last;
  logic              w_shift_ovf;

  assign w_mplier_nx  = r_mplier >> 1;
  assign w_mul_addend = r_mplier[0] ? r_mcand : '0;
  assign w_mul_last   = (r_iter == LAST_ITER);
  // A dropped mcand bit only matters if multiplier bits remain to consume it.
  assign w_shift_ovf  = r_mcand[WIDTH-1] && (w_mplier_nx != '0);
`endif

  assign w_req_ready = (r_state == ST_IDLE) && !rst;
  assign w_accept    = req_valid && w_req_ready;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nx;
    end
  end

  // Next-state decode and ALU operand/op drive for the current state.
  always_comb begin
    w_state_nx = r_state;
    w_alu_a    = '0;
    w_alu_b    = '0;
    w_alu_op   = OP_AND;
    w_alu_less = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          if (funct_legal(req_funct)) begin
            w_state_nx = ST_EXEC;
          end else begin
            w_state_nx = ST_RESP;
          end
        end else begin
          w_state_nx = ST_IDLE;
        end
      end
      ST_EXEC: begin
        w_alu_a  = r_a;
        w_alu_b  = r_b;
        w_alu_op = funct_to_op(r_funct);
        if (r_funct == FN_SLT) begin
          w_state_nx = ST_SLT2;
`ifdef ALU_SEQ_MUL_EN
        end else if (r_funct == FN_MUL) begin
          w_state_nx = ST_MUL;
`endif
        end else begin
          w_state_nx = ST_RESP;
        end
      end
      ST_SLT2: begin
        w_alu_a    = r_a;
        w_alu_b    = r_b;
        w_alu_op   = OP_SLT;
        w_alu_less = r_set;
        w_state_nx = ST_RESP;
      end
`ifdef ALU_SEQ_MUL_EN
      ST_MUL: begin
        w_alu_a  = r_acc;
        w_alu_b  = w_mul_addend;
        w_alu_op = OP_ADD;
        if (w_mul_last) begin
          w_state_nx = ST_RESP;
        end else begin
          w_state_nx = ST_MUL;
        end
      end
`endif
      ST_RESP: begin
        if (rsp_ready) begin
          w_state_nx = ST_IDLE;
        end else begin
          w_state_nx = ST_RESP;
        end
      end
      default: w_state_nx = ST_IDLE;
    endcase
  end

  // Request capture, SLT set flag, multiply datapath and response registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_funct        <= 4'd0;
      r_a            <= '0;
      r_b            <= '0;
      r_set          <= 1'b0;
      r_rsp_result   <= '0;
      r_rsp_zero     <= 1'b0;
      r_rsp_overflow <= 1'b0;
      r_rsp_cout     <= 1'b0;
      r_rsp_err      <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
      r_acc          <= '0;
      r_mcand        <= '0;
      r_mplier       <= '0;
      r_iter         <= '0;
      r_sticky_c     <= 1'b0;
      r_shift_ovf    <= 1'b0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_funct <= req_funct;
            r_a     <= req_a;
            r_b     <= req_b;
            if (!funct_legal(req_funct)) begin
              r_rsp_result   <= '0;
              r_rsp_zero     <= 1'b0;
              r_rsp_overflow <= 1'b0;
              r_rsp_cout     <= 1'b0;
              r_rsp_err      <= 1'b1;
            end
          end
        end
        ST_EXEC: begin
          if (r_funct == FN_SLT) begin
            r_set <= alu_set;
`ifdef ALU_SEQ_MUL_EN
          end else if (r_funct == FN_MUL) begin
            r_acc       <= '0;
            r_mcand     <= r_a;
            r_mplier    <= r_b;
            r_iter      <= '0;
            r_sticky_c  <= 1'b0;
            r_shift_ovf <= 1'b0;
`endif
          end else begin
            r_rsp_result   <= alu_result;
            r_rsp_zero     <= alu_zero;
            r_rsp_overflow <= alu_overflow;
            r_rsp_cout     <= alu_cout;
            r_rsp_err      <= 1'b0;
          end
        end
        ST_SLT2: begin
          r_rsp_result   <= alu_result;
          r_rsp_zero     <= alu_zero;
          r_rsp_overflow <= alu_overflow;
          r_rsp_cout     <= alu_cout;
          r_rsp_err      <= 1'b0;
        end
`ifdef ALU_SEQ_MUL_EN
        ST_MUL: begin
          r_acc       <= alu_result;
          r_mcand     <= r_mcand << 1;
          r_mplier    <= w_mplier_nx;
          r_iter      <= r_iter + ITER_W'(1);
          r_sticky_c  <= r_sticky_c | alu_cout;
          r_shift_ovf <= r_shift_ovf | w_shift_ovf;
          if (w_mul_last) begin
            r_rsp_result   <= alu_result;
            r_rsp_zero     <= (alu_result == '0);
            r_rsp_cout     <= r_sticky_c | alu_cout;
            r_rsp_overflow <= r_sticky_c | alu_cout | r_shift_ovf | w_shift_ovf;
            r_rsp_err      <= 1'b0;
          end
        end
`endif
        default: begin
          r_funct <= r_funct;
        end
      endcase
    end
  end

  assign req_ready    = w_req_ready;
  assign alu_a        = w_alu_a;
  assign alu_b        = w_alu_b;
  assign alu_op       = w_alu_op;
  assign alu_cin      = w_alu_op[2];
  assign alu_less     = w_alu_less;
  assign rsp_valid    = (r_state == ST_RESP);
  assign rsp_result   = r_rsp_result;
  assign rsp_zero     = r_rsp_zero;
  assign rsp_overflow = r_rsp_overflow;
  assign rsp_cout     = r_rsp_cout;
  assign rsp_err      = r_rsp_err;

endmodule
